async_queue_protocol_monitor: RTL and testbench

//  Multi-channel protocol checker for AsyncQueue source/sink pairs, observed in one clock domain.

---
 rtl/async_queue_protocol_monitor.sv | 134 +++++++++++++
 tb/tb_async_queue_protocol_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/async_queue_protocol_monitor.sv
// Passive per-channel AsyncQueue protocol checker: occupancy, overflow/underflow/valid-drop/timeout flags.
// Optional event printing is enabled with `define ASYNC_QUEUE_MONITOR_PRINTF_EN.
module async_queue_protocol_monitor #(
    parameter int NCH     = 1,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8,
    localparam int OW     = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NCH-1:0]      enq_valid,
    input  logic [NCH-1:0]      enq_ready,
    input  logic [NCH-1:0]      deq_valid,
    input  logic [NCH-1:0]      deq_ready,
    input  logic                err_clear,
    output logic [NCH*OW-1:0]   occupancy,
    output logic [NCH*4-1:0]    err_sticky,
    output logic                err_any,
    output logic [CNT_W-1:0]    err_count
);

    logic [NCH-1:0]           enq_fire, deq_fire;
    logic [NCH-1:0]           ovf_ev, udf_ev, vdrop_ev, tmo_ev;
    logic                     ev_any;
    logic [NCH-1:0][OW-1:0]   occ_q, occ_d;
    logic [NCH-1:0]           pend_q, pend_d;
    logic [NCH-1:0][3:0]      sticky_q, sticky_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;
    assign pend_d   = enq_valid & ~enq_ready;
    assign vdrop_ev = pend_q & ~enq_valid;

    // An underflowing dequeue and an overflowing enqueue are dropped from the count.
    always_comb begin
        occ_d  = occ_q;
        ovf_ev = '0;
        udf_ev = '0;
        for (int i = 0; i < NCH; i++) begin
            udf_ev[i] = deq_fire[i] && (occ_q[i] == '0);
            ovf_ev[i] = enq_fire[i] && !deq_fire[i] && (occ_q[i] == OW'(DEPTH));
            if (udf_ev[i])
                occ_d[i] = OW'(enq_fire[i]);
            else if (!ovf_ev[i])
                occ_d[i] = occ_q[i] + OW'(enq_fire[i]) - OW'(deq_fire[i]);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [NCH-1:0][TW-1:0] timer_q, timer_d;

            // Saturating timer; the event fires only on the step into TIMEOUT.
            always_comb begin
                timer_d = timer_q;
                tmo_ev  = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (deq_fire[i] || (occ_q[i] == '0)) begin
                        timer_d[i] = '0;
                    end else if (timer_q[i] != TW'(TIMEOUT)) begin
                        timer_d[i] = timer_q[i] + TW'(1);
                        tmo_ev[i]  = (timer_q[i] == TW'(TIMEOUT - 1));
                    end
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) timer_q <= '0;
                else       timer_q <= timer_d;
            end
        end else begin : g_no_tmo
            assign tmo_ev = '0;
        end
    endgenerate

    assign ev_any = |{ovf_ev, udf_ev, vdrop_ev, tmo_ev};

    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < NCH; i++) begin
            sticky_d[i] = (err_clear ? 4'b0000 : sticky_q[i])
                        | {tmo_ev[i], vdrop_ev[i], udf_ev[i], ovf_ev[i]};
        end
    end

    // A simultaneous event beats err_clear: the count restarts at one.
    always_comb begin
        cnt_d = cnt_q;
        if (ev_any) begin
            if (err_clear)                   cnt_d = CNT_W'(1);
            else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end else if (err_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q    <= '0;
            pend_q   <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            occ_q    <= occ_d;
            pend_q   <= pend_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign occupancy  = occ_q;
    assign err_sticky = sticky_q;
    assign err_any    = |sticky_q;
    assign err_count  = cnt_q;

`ifdef ASYNC_QUEUE_MONITOR_PRINTF_EN
`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                if (ovf_ev[i])   $display("overflow ch=%0d occ=%0d", i, occ_q[i]);
                if (udf_ev[i])   $display("underflow ch=%0d occ=%0d", i, occ_q[i]);
                if (vdrop_ev[i]) $display("valid_drop ch=%0d occ=%0d", i, occ_q[i]);
                if (tmo_ev[i])   $display("timeout ch=%0d occ=%0d", i, occ_q[i]);
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_async_queue_protocol_monitor.sv
// Directed bench: instance A (2 ch, no timeout) and instance B (1 ch, TIMEOUT=4, CNT_W=2).
module tb_async_queue_protocol_monitor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0] a_ev, a_er, a_dv, a_dr;
    logic       a_clr;
    logic [7:0] a_occ, a_sticky, a_count;
    logic       a_any;

    logic [0:0] b_ev, b_er, b_dv, b_dr;
    logic       b_clr;
    logic [3:0] b_occ, b_sticky;
    logic [1:0] b_count;
    logic       b_any;

    int n_cmp = 0;
    int n_err = 0;

    async_queue_protocol_monitor #(.NCH(2), .DEPTH(8), .TIMEOUT(0), .CNT_W(8)) dut_a (
        .clock(clk), .reset(reset),
        .enq_valid(a_ev), .enq_ready(a_er), .deq_valid(a_dv), .deq_ready(a_dr),
        .err_clear(a_clr),
        .occupancy(a_occ), .err_sticky(a_sticky), .err_any(a_any), .err_count(a_count)
    );

    async_queue_protocol_monitor #(.NCH(1), .DEPTH(8), .TIMEOUT(4), .CNT_W(2)) dut_b (
        .clock(clk), .reset(reset),
        .enq_valid(b_ev), .enq_ready(b_er), .deq_valid(b_dv), .deq_ready(b_dr),
        .err_clear(b_clr),
        .occupancy(b_occ), .err_sticky(b_sticky), .err_any(b_any), .err_count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_ev = '0; a_er = '0; a_dv = '0; a_dr = '0; a_clr = 1'b0;
        b_ev = '0; b_er = '0; b_dv = '0; b_dr = '0; b_clr = 1'b0;
        #1;
        chk("rst_a_occ",    a_occ,    0);
        chk("rst_a_sticky", a_sticky, 0);
        chk("rst_a_count",  a_count,  0);
        chk("rst_a_any",    a_any,    0);
        chk("rst_b_occ",    b_occ,    0);
        step();
        reset = 1'b0;
        step();

        // ---- instance A: fill / drain ----
        a_ev = 2'b01; a_er = 2'b01;
        repeat (8) step();
        a_ev = 2'b00;
        chk("fill_occ", a_occ, 8'h08);
        chk("fill_any", a_any, 0);
        a_dv = 2'b01; a_dr = 2'b01;
        repeat (8) step();
        a_dv = 2'b00;
        chk("drain_occ",   a_occ,   8'h00);
        chk("drain_any",   a_any,   0);
        chk("drain_count", a_count, 0);

        // ---- overflow ----
        a_ev = 2'b01;
        repeat (8) step();
        step();
        a_ev = 2'b00;
        chk("ovf_sticky", a_sticky, 8'h01);
        chk("ovf_occ",    a_occ,    8'h08);
        chk("ovf_count",  a_count,  1);
        a_ev = 2'b01; a_dv = 2'b01;
        step();
        a_ev = 2'b00; a_dv = 2'b00;
        chk("full_both_sticky", a_sticky, 8'h01);
        chk("full_both_occ",    a_occ,    8'h08);
        chk("full_both_count",  a_count,  1);

        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("clr_sticky", a_sticky, 0);
        chk("clr_count",  a_count,  0);
        chk("clr_any",    a_any,    0);
        a_dv = 2'b01;
        repeat (8) step();
        a_dv = 2'b00;
        chk("drain2_occ", a_occ, 8'h00);

        // ---- underflow, valid-drop ----
        a_dv = 2'b01;
        step();
        a_dv = 2'b00;
        chk("udf_sticky", a_sticky, 8'h02);
        chk("udf_occ",    a_occ,    8'h00);
        chk("udf_count",  a_count,  1);
        chk("udf_any",    a_any,    1);
        a_ev = 2'b01; a_er = 2'b00;
        step();
        chk("vd_pend_count", a_count, 1);
        a_ev = 2'b00;
        step();
        chk("vd_sticky", a_sticky, 8'h06);
        chk("vd_count",  a_count,  2);

        // ---- four events on two channels in one cycle count once ----
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        a_ev = 2'b11; a_er = 2'b00;
        step();
        a_ev = 2'b00; a_dv = 2'b11; a_dr = 2'b11;
        step();
        a_dv = 2'b00;
        chk("multi_sticky", a_sticky, 8'h66);
        chk("multi_count",  a_count,  1);
        chk("multi_occ",    a_occ,    8'h00);

        // ---- enq+deq at empty on ch1: underflow, occ becomes 1 ----
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        a_ev = 2'b10; a_er = 2'b10; a_dv = 2'b10; a_dr = 2'b10;
        step();
        a_ev = 2'b00; a_dv = 2'b00;
        chk("empty_both_occ",    a_occ,    8'h10);
        chk("empty_both_sticky", a_sticky, 8'h20);
        chk("empty_both_count",  a_count,  1);

        // ---- asynchronous reset mid-traffic ----
        a_ev = 2'b01; a_er = 2'b11;
        repeat (5) step();
        a_ev = 2'b00;
        chk("pre_rst_occ", a_occ, 8'h15);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_occ",    a_occ,    0);
        chk("mid_rst_sticky", a_sticky, 0);
        chk("mid_rst_count",  a_count,  0);
        chk("mid_rst_any",    a_any,    0);
        #1 reset = 1'b0;
        step();
        chk("post_rst_occ", a_occ, 0);

        // ---- instance B: timeout ----
        b_er = 1'b1; b_dr = 1'b1;
        b_ev = 1'b1;
        step();
        b_ev = 1'b0;
        repeat (3) step();
        chk("tmo_early_sticky", b_sticky, 0);
        chk("tmo_early_count",  b_count,  0);
        step();
        chk("tmo_sticky", b_sticky, 4'h8);
        chk("tmo_count",  b_count,  1);
        repeat (2) step();
        chk("tmo_once_count", b_count, 1);
        chk("tmo_once_occ",   b_occ,   1);
        b_ev = 1'b1; b_dv = 1'b1;
        step();
        b_ev = 1'b0; b_dv = 1'b0;
        repeat (3) step();
        chk("tmo_rearm_early", b_count, 1);
        step();
        chk("tmo_rearm_count", b_count, 2);
        b_dv = 1'b1;
        step();
        b_dv = 1'b0;
        chk("tmo_drain_occ", b_occ, 0);

        // ---- saturation and clear-vs-event ----
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        chk("b_clr_count",  b_count,  0);
        chk("b_clr_sticky", b_sticky, 0);
        b_dv = 1'b1;
        repeat (2) step();
        chk("sat_two", b_count, 2);
        repeat (3) step();
        b_dv = 1'b0;
        chk("sat_count",  b_count,  3);
        chk("sat_sticky", b_sticky, 4'h2);
        b_ev = 1'b1;
        repeat (8) step();
        chk("sat_fill_occ", b_occ, 8);
        b_clr = 1'b1;
        step();
        b_clr = 1'b0; b_ev = 1'b0;
        chk("clr_ovf_count",  b_count,  1);
        chk("clr_ovf_sticky", b_sticky, 4'h1);
        chk("clr_ovf_occ",    b_occ,    8);
        chk("clr_ovf_any",    b_any,    1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
